// File: rtl/banco_registros.sv
// Two-read/one-write register file with register 0 hardwired to zero and a sequential dump port.
// Optional write-to-read forwarding on rd1/rd2 when BANCO_REGISTROS_BYPASS_EN is defined.
module banco_registros #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              dump_start,
    output logic              dump_busy,
    output logic              dump_valid,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    logic [DATA_W-1:0] regs [DEPTH];
    logic              wr_en;
    logic [DATA_W-1:0] stored1;
    logic [DATA_W-1:0] stored2;
    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addr_nxt;

    assign wr_en = we && (wa != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wa] <= wd;
        end
    end

    always_comb begin
        stored1 = (ra1 == '0) ? '0 : regs[ra1];
        stored2 = (ra2 == '0) ? '0 : regs[ra2];
    end

`ifdef BANCO_REGISTROS_BYPASS_EN
    // Forwarding is suppressed during reset so the read ports stay at zero.
    always_comb begin
        rd1 = (!rst && wr_en && (wa == ra1)) ? wd : stored1;
        rd2 = (!rst && wr_en && (wa == ra2)) ? wd : stored2;
    end
`else
    always_comb begin
        rd1 = stored1;
        rd2 = stored2;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            dump_addr <= '0;
        end else begin
            state     <= state_nxt;
            dump_addr <= addr_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        addr_nxt   = dump_addr;
        dump_busy  = 1'b0;
        dump_valid = 1'b0;
        case (state)
            IDLE: begin
                addr_nxt = '0;
                if (dump_start) begin
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                dump_busy  = 1'b1;
                dump_valid = 1'b1;
                addr_nxt   = dump_addr + 1'b1;
                if (dump_addr == '1) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                addr_nxt  = '0;
            end
        endcase
    end

    assign dump_data = (dump_addr == '0) ? '0 : regs[dump_addr];

endmodule

// File: tb/tb_banco_registros.sv
// Randomized self-checking bench for banco_registros against an array-based reference model.
module tb_banco_registros;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          we = 1'b0;
    logic [AW-1:0] wa = '0;
    logic [DW-1:0] wd = '0;
    logic [AW-1:0] ra1 = '0;
    logic [AW-1:0] ra2 = '0;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic          dump_start = 1'b0;
    logic          dump_busy;
    logic          dump_valid;
    logic [AW-1:0] dump_addr;
    logic [DW-1:0] dump_data;

    logic [DW-1:0] model [32];
    int            checks = 0;
    int            errors = 0;

    banco_registros #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .dump_start(dump_start), .dump_busy(dump_busy), .dump_valid(dump_valid),
        .dump_addr(dump_addr), .dump_data(dump_data)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] expect_rd(input logic [AW-1:0] ra);
        if (ra == 0) return '0;
`ifdef BANCO_REGISTROS_BYPASS_EN
        if (!rst && we && wa != 0 && wa == ra) return wd;
`endif
        return model[ra];
    endfunction

    // Advance one clock, applying the pending write to the model as the design should.
    task automatic tick();
        @(posedge clk);
        if (!rst && we && wa != 0) model[wa] = wd;
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = '0;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        clear_model();
        #1;
        checks++;
        if (dump_busy !== 1'b0 || dump_valid !== 1'b0 || dump_addr !== '0) begin
            errors++;
            $display("FAIL reset_dump busy=%b valid=%b addr=%0d required 0/0/0", dump_busy, dump_valid, dump_addr);
        end
        we = 1'b1; wa = 5'd3; wd = 32'hDEADBEEF; ra1 = 5'd3; ra2 = 5'd9;
        @(posedge clk); #2;
        checks++;
        if (rd1 !== '0 || rd2 !== '0) begin
            errors++;
            $display("FAIL reset_reads rd1=%h rd2=%h required 0", rd1, rd2);
        end
        @(negedge clk);
        rst = 1'b0; we = 1'b0;
        #1;
        checks++;
        if (rd1 !== '0) begin
            errors++;
            $display("FAIL reset_write_discard rd1=%h required 0", rd1);
        end
    endtask

    task automatic test_write_read();
        @(posedge clk); #1;
        we = 1'b1; wa = 5'd5; wd = 32'h020F7A43; ra1 = 5'd0;
        tick();
        we = 1'b0; ra1 = 5'd5;
        #1;
        checks++;
        if (rd1 !== 32'h020F7A43) begin
            errors++;
            $display("FAIL write_read rd1=%h required %h", rd1, 32'h020F7A43);
        end
    endtask

    task automatic test_reg0();
        we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF; ra1 = 5'd0; ra2 = 5'd0;
        #1;
        checks++;
        if (rd1 !== '0 || rd2 !== '0) begin
            errors++;
            $display("FAIL reg0_same_cycle rd1=%h rd2=%h required 0", rd1, rd2);
        end
        tick();
        we = 1'b0;
        #1;
        checks++;
        if (rd1 !== '0 || rd2 !== '0) begin
            errors++;
            $display("FAIL reg0_after rd1=%h rd2=%h required 0", rd1, rd2);
        end
    endtask

    task automatic test_same_cycle();
        logic [DW-1:0] exp;
        we = 1'b1; wa = 5'd7; wd = 32'h12345678; ra2 = 5'd7;
`ifdef BANCO_REGISTROS_BYPASS_EN
        exp = 32'h12345678;
`else
        exp = model[7];
`endif
        #1;
        checks++;
        if (rd2 !== exp) begin
            errors++;
            $display("FAIL same_cycle rd2=%h required %h", rd2, exp);
        end
        tick();
        we = 1'b0;
        #1;
        checks++;
        if (rd2 !== 32'h12345678) begin
            errors++;
            $display("FAIL next_cycle rd2=%h required %h", rd2, 32'h12345678);
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] e1, e2;
        for (int n = 0; n < 300; n++) begin
            we  = 1'($urandom_range(0, 1));
            wa  = AW'($urandom_range(0, 31));
            wd  = $urandom;
            ra1 = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, 31));
            ra2 = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, 31));
            #1;
            e1 = expect_rd(ra1);
            e2 = expect_rd(ra2);
            checks++;
            if (rd1 !== e1) begin
                errors++;
                $display("FAIL random_rd1 ra1=%0d rd1=%h required %h", ra1, rd1, e1);
            end
            checks++;
            if (rd2 !== e2) begin
                errors++;
                $display("FAIL random_rd2 ra2=%0d rd2=%h required %h", ra2, rd2, e2);
            end
            tick();
        end
        we = 1'b0;
    endtask

    task automatic test_dump();
        logic [DW-1:0] e1;
        for (int k = 1; k < 32; k++) begin
            we = 1'b1; wa = AW'(k); wd = DW'(k * 3);
            tick();
        end
        we = 1'b0;
        dump_start = 1'b1;
        #1;
        checks++;
        if (dump_busy !== 1'b0 || dump_valid !== 1'b0 || dump_addr !== '0) begin
            errors++;
            $display("FAIL dump_idle busy=%b valid=%b addr=%0d required 0/0/0", dump_busy, dump_valid, dump_addr);
        end
        tick();
        dump_start = 1'b0;
        for (int i = 0; i < 32; i++) begin
            dump_start = (i == 10 || i == 31);
            // Occasional writes, including to the register being dumped, must not bypass the dump port.
            we  = (i == 20) ? 1'b1 : 1'($urandom_range(0, 1));
            wa  = (i == 20) ? 5'd20 : AW'($urandom_range(0, 31));
            wd  = $urandom;
            ra1 = AW'($urandom_range(0, 31));
            #1;
            e1 = expect_rd(ra1);
            checks++;
            if (dump_valid !== 1'b1 || dump_busy !== 1'b1 || dump_addr !== AW'(i)) begin
                errors++;
                $display("FAIL dump_seq i=%0d busy=%b valid=%b addr=%0d required 1/1/%0d", i, dump_busy, dump_valid, dump_addr, i);
            end
            checks++;
            if (dump_data !== model[i]) begin
                errors++;
                $display("FAIL dump_data addr=%0d data=%h required %h", i, dump_data, model[i]);
            end
            checks++;
            if (rd1 !== e1) begin
                errors++;
                $display("FAIL dump_rd1 ra1=%0d rd1=%h required %h", ra1, rd1, e1);
            end
            tick();
        end
        dump_start = 1'b0; we = 1'b0;
        for (int j = 0; j < 3; j++) begin
            #1;
            checks++;
            if (dump_busy !== 1'b0 || dump_valid !== 1'b0 || dump_addr !== '0) begin
                errors++;
                $display("FAIL dump_end j=%0d busy=%b valid=%b addr=%0d required 0/0/0", j, dump_busy, dump_valid, dump_addr);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_dump();
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        #1;
        checks++;
        if (dump_addr !== 5'd12 || dump_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_abort addr=%0d valid=%b required 12/1", dump_addr, dump_valid);
        end
        #1 rst = 1'b1;
        clear_model();
        #1;
        checks++;
        if (dump_busy !== 1'b0 || dump_valid !== 1'b0 || dump_addr !== '0) begin
            errors++;
            $display("FAIL abort busy=%b valid=%b addr=%0d required 0/0/0", dump_busy, dump_valid, dump_addr);
        end
        we = 1'b1; wa = 5'd4; wd = 32'hA5A5A5A5;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; we = 1'b0;
        for (int r = 0; r < 32; r++) begin
            ra1 = AW'(r); ra2 = AW'(31 - r);
            #1;
            checks++;
            if (rd1 !== '0 || rd2 !== '0) begin
                errors++;
                $display("FAIL post_reset_reg r=%0d rd1=%h rd2=%h required 0", r, rd1, rd2);
            end
        end
        for (int j = 0; j < 5; j++) begin
            tick();
            checks++;
            if (dump_valid !== 1'b0 || dump_busy !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_idle j=%0d busy=%b valid=%b required 0/0", j, dump_busy, dump_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_reg0();
        test_same_cycle();
        test_random();
        test_dump();
        test_reset_mid_dump();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/banco_registros.md
BANCO_REGISTROS -- requirements
Module: banco_registros

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the register data width in bits.
REQ-002 Parameter ADDR_W, default 5, SHALL set the register address width; depth is 2**ADDR_W (32).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 we  input  1  SHALL be the write enable.
REQ-006 wa  input  ADDR_W  SHALL be the write address.
REQ-007 wd  input  DATA_W  SHALL be the write data.
REQ-008 ra1  input  ADDR_W  SHALL be the read port 1 address.
REQ-009 ra2  input  ADDR_W  SHALL be the read port 2 address.
REQ-010 rd1  output  DATA_W  SHALL be the read port 1 data (combinational).
REQ-011 rd2  output  DATA_W  SHALL be the read port 2 data (combinational).
REQ-012 dump_start  input  1  SHALL request a sequential readout of all registers.
REQ-013 dump_busy  output  1  SHALL be high while a readout is in progress.
REQ-014 dump_valid  output  1  SHALL qualify dump_addr and dump_data.
REQ-015 dump_addr  output  ADDR_W  SHALL be the address of the register currently presented.
REQ-016 dump_data  output  DATA_W  SHALL be the contents of register dump_addr.

Function
REQ-017 A write SHALL occur on the rising edge when we=1 and wa!=0; writes to address 0 SHALL be discarded.
REQ-018 Register 0 SHALL read as 0 on every port at all times.
REQ-019 rd1/rd2 SHALL reflect regs[ra1]/regs[ra2] combinationally, with zero-cycle latency.
REQ-020 Both read ports and the dump port SHALL operate independently in the same cycle, including when they address the same register.
REQ-021 The dump FSM SHALL have exactly two states: IDLE and SCAN.
REQ-022 In IDLE with dump_start=1 at a rising edge, the FSM SHALL enter SCAN with dump_addr=0.
REQ-023 In SCAN, dump_busy=1 and dump_valid=1 SHALL hold every cycle, and dump_data SHALL equal regs[dump_addr] combinationally.
REQ-024 In SCAN, dump_addr SHALL increment by 1 per clock; on the edge where dump_addr=31 it SHALL wrap to 0 and the FSM SHALL return to IDLE. A readout is therefore exactly 32 valid cycles.
REQ-025 dump_start while in SCAN, including on the final scan cycle, SHALL be ignored; no queuing.
REQ-026 A write to address N in the same cycle dump_addr=N SHALL present the pre-write value on dump_data; the dump port never bypasses.
REQ-027 In IDLE: dump_busy=0, dump_valid=0, dump_addr=0.
REQ-028 Ordinary reads and writes SHALL NOT be stalled or altered by a readout.

Reset
REQ-029 While rst=1, all registers SHALL be 0, the FSM SHALL be in IDLE, dump_addr=0, and dump_busy=dump_valid=0, independent of clk.
REQ-030 rst asserted mid-SCAN SHALL abort the readout immediately; no further dump_valid until a new dump_start.
REQ-031 With rst=1, rd1=rd2=0; writes presented during reset SHALL be discarded.

Configuration
REQ-032 Macro BANCO_REGISTROS_BYPASS_EN defined: if we=1, wa!=0 and wa==ra1 (or ra2), rd1 (or rd2) SHALL return wd in the same cycle (write-to-read forwarding).
REQ-033 Macro BANCO_REGISTROS_BYPASS_EN undefined: rd1/rd2 SHALL return the stored pre-write value in that cycle and the new value from the next cycle.

Verification
REQ-034 Reset, then write 0x020F7A43 to reg 5, then ra1=5 -> rd1=0x020F7A43 on the cycle after the write edge.
REQ-035 Write 0xFFFFFFFF to reg 0, then ra1=ra2=0 -> rd1=rd2=0.
REQ-036 we=1, wa=7, wd=0x12345678, ra2=7 in the same cycle -> rd2=0x12345678 with the BYPASS macro defined; rd2=prior value (0 after reset) without it.
REQ-037 Load reg k=k*3 for k=1..31, pulse dump_start -> 32 consecutive valid cycles with addr 0..31 and data 0,3,...,93; busy drops after addr 31; a second dump_start at addr 10 is ignored.
REQ-038 Assert rst asynchronously (between edges) at dump_addr=12 -> busy/valid drop at once; all registers read 0 afterwards; no further valid until a new dump_start.
